// File: rtl/rca_operand_feeder_pkg.sv
// Shared constants, FSM state type and LFSR step function for the
// 128-bit ripple-carry adder operand feeder.
package rca_feeder_pkg;

    localparam int WIDTH = 128;
    localparam int CNT_W = 32;

    // Galois feedback mask for x^128 + x^127 + x^126 + x^121 + 1.
    // The x^128 term is implicit (it is the bit shifted out).
    localparam logic [WIDTH-1:0] POLY = (128'h1 << 127) | (128'h1 << 126) |
                                        (128'h1 << 121) | 128'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_e;

    // One Galois step: shift left, fold the outgoing MSB back through POLY.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
    endfunction

endpackage

// File: rtl/rca_operand_feeder_if.sv
// Control/operand bundle between the stimulus driver and the operand feeder.
interface rca_operand_feeder_if;
    import rca_feeder_pkg::*;

    logic             seed_load;
    logic [WIDTH-1:0] seed_a;
    logic [WIDTH-1:0] seed_b;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             stop;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issued;

    // Driver side: issues commands, observes operands and status.
    modport master (
        output seed_load, seed_a, seed_b, start, count, stop,
        input  a_out, b_out, valid, busy, done, issued
    );

    // Feeder side.
    modport slave (
        input  seed_load, seed_a, seed_b, start, count, stop,
        output a_out, b_out, valid, busy, done, issued
    );

endinterface

// File: rtl/rca_operand_feeder_lfsr.sv
// 128-bit Galois LFSR with parameterised reset seed, seed load and step
// enable. A zero seed would lock the register at zero forever, so it is
// replaced with 1 on load.
module galois_lfsr_128
    import rca_feeder_pkg::*;
#(
    parameter logic [WIDTH-1:0] RST_SEED = 128'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] load_val;

    // Zero-seed substitution for the load path.
    always_comb begin
        load_val = (seed == '0) ? WIDTH'(1) : seed;
    end

    // LFSR register: reset seed, then load has priority over step.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        if (rst) begin
            state_q <= RST_SEED;
        end else if (load) begin
            state_q <= load_val;
        end else if (step) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rca_operand_feeder.sv
// Operand feeder: two Galois LFSRs plus a control FSM issue a programmed
// number of pseudo-random operand pairs, one per clock, on registered
// outputs feeding the adder's a/b inputs.
module rca_operand_feeder
    import rca_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rca_operand_feeder_if.slave  bus
);

    feeder_state_e    state_q;
    logic [WIDTH-1:0] a_out_q;
    logic [WIDTH-1:0] b_out_q;
    logic             valid_q;
    logic             done_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] issued_d;
    logic [CNT_W-1:0] target_q;

    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             is_run;

    // Command decode: seeds are accepted only outside RUN; the LFSRs advance
    // exactly when a pair is issued, so a stop cycle leaves them untouched.
    always_comb begin
        // NOTE: every signal gets an unconditional value here, so no latch
        // can be inferred from a missing branch.
        is_run    = (state_q == RUN);
        lfsr_load = !is_run && bus.seed_load;
        lfsr_step = is_run && !bus.stop;
        issued_d  = issued_q + CNT_W'(1);
    end

    galois_lfsr_128 #(
        .RST_SEED (128'h1)
    ) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (bus.seed_a),
        .step  (lfsr_step),
        .state (lfsr_a)
    );

    galois_lfsr_128 #(
        .RST_SEED (128'h2)
    ) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (bus.seed_b),
        .step  (lfsr_step),
        .state (lfsr_b)
    );

    // Control FSM with registered operand and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_out_q  <= '0;
            b_out_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            issued_q <= '0;
            target_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // A zero-length run goes straight to DONE.
                        target_q <= bus.count;
                        issued_q <= '0;
                        done_q   <= (bus.count == '0);
                        state_q  <= (bus.count == '0) ? DONE : RUN;
                    end else if (bus.seed_load) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (state_q == DONE) begin
                        // Raised one cycle after the final valid pair.
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        a_out_q  <= lfsr_a;
                        b_out_q  <= lfsr_b;
                        valid_q  <= 1'b1;
                        issued_q <= issued_d;
                        if (issued_d == target_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_out  = a_out_q;
    assign bus.b_out  = b_out_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = is_run;
    assign bus.done   = done_q;
    assign bus.issued = issued_q;

endmodule

// File: tb/tb_rca_operand_feeder.sv
// Self-checking bench for rca_operand_feeder: a reference LFSR model pushes
// expected operand pairs to a queue as runs are started; a negedge monitor
// pops and compares every valid pair.
module tb_rca_operand_feeder;

    localparam logic [127:0] TB_POLY = (128'h1 << 127) | (128'h1 << 126) |
                                       (128'h1 << 121) | 128'h1;
    localparam logic [127:0] TB_TOP  = 128'h1 << 127;

    logic clk;
    logic rst;

    rca_operand_feeder_if bus ();

    rca_operand_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int vcount       = 0;

    logic [255:0] exp_q[$];
    logic [127:0] ma;
    logic [127:0] mb;

    function automatic logic [127:0] model_next(input logic [127:0] s);
        logic [127:0] r;
        r = s << 1;
        if (s[127]) r = r ^ TB_POLY;
        return r;
    endfunction

    task automatic model_load(input logic [127:0] sa, input logic [127:0] sb);
        ma = (sa == 128'h0) ? 128'h1 : sa;
        mb = (sb == 128'h0) ? 128'h1 : sb;
    endtask

    task automatic push_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ma, mb});
            ma = model_next(ma);
            mb = model_next(mb);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid pair must match the next expected pair.
    always @(negedge clk) begin
        if (!rst && bus.valid === 1'b1) begin
            logic [255:0] e;
            vcount++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid: got a=%h, no pair expected", bus.a_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.a_out !== e[255:128] || bus.b_out !== e[127:0]) begin
                    tests_failed++;
                    $display("FAIL pair: got a=%h b=%h want a=%h b=%h",
                             bus.a_out, bus.b_out, e[255:128], e[127:0]);
                end
            end
        end
    end

    task automatic start_run(input logic [31:0] n);
        vcount    = 0;
        bus.start = 1'b1;
        bus.count = n;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic seed(input logic [127:0] sa, input logic [127:0] sb);
        bus.seed_a    = sa;
        bus.seed_b    = sb;
        bus.seed_load = 1'b1;
        model_load(sa, sb);
        cycle();
        bus.seed_load = 1'b0;
    endtask

    // Bounded wait for done, then check end-of-run status.
    task automatic finish_run(input string name, input int n);
        for (int i = 0; i < n + 8 && bus.done !== 1'b1; i++) cycle();
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done: got %b want 1 (timeout)", name, bus.done);
        end
        tests_run++;
        if (bus.issued !== 32'(n)) begin
            tests_failed++;
            $display("FAIL %s_issued: got %0d want %0d", name, bus.issued, n);
        end
        tests_run++;
        if (vcount != n || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_valid_count: got %0d (left %0d) want %0d",
                     name, vcount, exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        tests_run++;
        if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got v/b/d=%b want 000", {bus.valid, bus.busy, bus.done});
        end
        tests_run++;
        if (bus.a_out !== 128'h0 || bus.b_out !== 128'h0 || bus.issued !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got a=%h b=%h issued=%0d want 0",
                     bus.a_out, bus.b_out, bus.issued);
        end
        rst = 1'b0;
        ma  = 128'h1;
        mb  = 128'h2;
    endtask

    task automatic test_basic();
        seed(128'h1, 128'h3);
        push_pairs(3);
        start_run(3);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_first_cycle: got busy=%b valid=%b want 1 0", bus.busy, bus.valid);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            tests_run++;
            if (bus.valid !== 1'b1 || bus.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_valid_%0d: got valid=%b done=%b want 1 0", i, bus.valid, bus.done);
            end
        end
        cycle();
        tests_run++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_end: got valid=%b done=%b busy=%b want 0 1 0",
                     bus.valid, bus.done, bus.busy);
        end
        finish_run("basic", 3);
    endtask

    task automatic test_long();
        seed(128'h1, 128'h3);
        push_pairs(129);
        start_run(129);
        for (int i = 1; i <= 129; i++) begin
            cycle();
            tests_run++;
            if (bus.valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL long_valid_%0d: got %b want 1", i, bus.valid);
            end
            if (i == 128) begin
                tests_run++;
                if (bus.a_out !== TB_TOP) begin
                    tests_failed++;
                    $display("FAIL long_a128: got %h want %h", bus.a_out, TB_TOP);
                end
            end
            if (i == 129) begin
                tests_run++;
                if (bus.a_out !== TB_POLY) begin
                    tests_failed++;
                    $display("FAIL long_a129: got %h want %h", bus.a_out, TB_POLY);
                end
            end
        end
        cycle();
        tests_run++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_end: got done=%b valid=%b want 1 0", bus.done, bus.valid);
        end
        finish_run("long", 129);
    endtask

    task automatic test_zero_count();
        seed(128'h9, 128'hA);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_seed_clears_done: got %b want 0", bus.done);
        end
        start_run(0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: got done=%b valid=%b busy=%b want 1 0 0",
                     bus.done, bus.valid, bus.busy);
        end
        cycle();
        cycle();
        finish_run("zero", 0);
    endtask

    task automatic test_stop();
        logic [127:0] third_a;
        push_pairs(3);
        third_a = exp_q[2][255:128];
        start_run(10);
        cycle();
        cycle();
        cycle();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        tests_run++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_status: got valid=%b done=%b busy=%b want 0 1 0",
                     bus.valid, bus.done, bus.busy);
        end
        tests_run++;
        if (bus.a_out !== third_a) begin
            tests_failed++;
            $display("FAIL stop_hold: got %h want %h", bus.a_out, third_a);
        end
        cycle();
        cycle();
        finish_run("stop", 3);
    endtask

    task automatic test_back_to_back();
        push_pairs(3);
        start_run(3);
        finish_run("back_to_back", 3);
    endtask

    task automatic test_zero_seed_and_ignore();
        seed(128'h0, 128'h1234_5678);
        push_pairs(6);
        start_run(6);
        cycle();
        tests_run++;
        if (bus.a_out !== 128'h1) begin
            tests_failed++;
            $display("FAIL zero_seed_first: got %h want 1", bus.a_out);
        end
        bus.seed_a    = 128'h99;
        bus.seed_b    = 128'h77;
        bus.seed_load = 1'b1;
        bus.start     = 1'b1;
        bus.count     = 32'd2;
        cycle();
        bus.seed_load = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        finish_run("ignore_in_run", 6);
    endtask

    task automatic test_load_and_start();
        bus.seed_a    = 128'h5;
        bus.seed_b    = 128'h7;
        bus.seed_load = 1'b1;
        model_load(128'h5, 128'h7);
        push_pairs(2);
        start_run(2);
        bus.seed_load = 1'b0;
        finish_run("load_and_start", 2);
    endtask

    task automatic test_rst_mid_run();
        push_pairs(20);
        start_run(20);
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        tests_run++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_flags: got valid=%b busy=%b done=%b want 0 0 0",
                     bus.valid, bus.busy, bus.done);
        end
        tests_run++;
        if (bus.a_out !== 128'h0 || bus.issued !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got a=%h issued=%0d want 0 0", bus.a_out, bus.issued);
        end
        rst = 1'b0;
        exp_q.delete();
        ma = 128'h1;
        mb = 128'h2;
        push_pairs(4);
        start_run(4);
        finish_run("after_rst", 4);
    endtask

    initial begin
        rst           = 1'b1;
        bus.seed_load = 1'b0;
        bus.seed_a    = '0;
        bus.seed_b    = '0;
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.stop      = 1'b0;
        ma            = 128'h1;
        mb            = 128'h2;

        test_reset();
        test_basic();
        test_long();
        test_zero_count();
        test_stop();
        test_back_to_back();
        test_zero_seed_and_ignore();
        test_load_and_start();
        test_rst_mid_run();

        cycle();
        cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
